// File: rtl/input_scheduler.sv
// Turns debounced button levels into single-cycle game commands with DAS/ARR
// shifting, repeating soft drop and edge-only rotate/hard drop.
module input_scheduler #(
    parameter int DAS_FRAMES = 10,
    parameter int ARR_FRAMES = 3,
    parameter int SDR_FRAMES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tick_game,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_down,
    input  logic btn_rotate,
    input  logic btn_drop,
    input  logic ready,
    input  logic flush,
    output logic cmd_left,
    output logic cmd_right,
    output logic cmd_down,
    output logic cmd_rotate,
    output logic cmd_drop
);
    typedef enum logic [1:0] {S_IDLE, S_DAS, S_ARR} shift_state_t;

    localparam int P_L    = 0;
    localparam int P_R    = 1;
    localparam int P_D    = 2;
    localparam int P_ROT  = 3;
    localparam int P_DROP = 4;

    localparam logic [5:0] DAS_N = 6'(DAS_FRAMES);
    localparam logic [5:0] ARR_N = 6'(ARR_FRAMES);
    localparam logic [5:0] SDR_N = 6'(SDR_FRAMES);

    logic [4:0]   btn;
    logic [4:0]   press;
    logic [4:0]   prev_q;
    logic [4:0]   pend_q, pend_d;
    logic [4:0]   cmd_q, cmd_d;
    logic [4:0]   set_v;
    logic [1:0]   sh_btn, sh_press, sh_set;
    logic         dir_q, dir_d;
    shift_state_t state_q, state_d;
    logic [5:0]   sh_cnt_q, sh_cnt_d, sh_cnt_inc, sh_limit;
    logic [5:0]   sd_cnt_q, sd_cnt_d, sd_cnt_inc;
    logic         issue_ok;

    assign btn        = {btn_drop, btn_rotate, btn_down, btn_right, btn_left};
    assign press      = btn & ~prev_q;
    assign sh_btn     = btn[1:0];
    assign sh_press   = press[1:0];
    assign sh_cnt_inc = sh_cnt_q + 6'd1;
    assign sd_cnt_inc = sd_cnt_q + 6'd1;
    assign sh_limit   = (state_q == S_DAS) ? DAS_N : ARR_N;
    // A command pulse blocks issue for its own cycle, giving the mandatory gap.
    assign issue_ok   = ready && (cmd_q == 5'b0) && !flush;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q   <= btn;   // held buttons must not look like presses after reset
            pend_q   <= '0;
            cmd_q    <= '0;
            state_q  <= S_IDLE;
            dir_q    <= 1'b0;
            sh_cnt_q <= '0;
            sd_cnt_q <= '0;
        end else begin
            prev_q   <= btn;
            pend_q   <= pend_d;
            cmd_q    <= cmd_d;
            state_q  <= state_d;
            dir_q    <= dir_d;
            sh_cnt_q <= sh_cnt_d;
            sd_cnt_q <= sd_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        sh_cnt_d = sh_cnt_q;
        sd_cnt_d = sd_cnt_q;
        sh_set   = 2'b00;
        set_v    = 5'b0;
        cmd_d    = 5'b0;

        set_v[P_ROT]  = press[P_ROT];
        set_v[P_DROP] = press[P_DROP];

        if (press[P_D]) begin
            set_v[P_D] = 1'b1;
            sd_cnt_d   = '0;
        end else if (!btn[P_D]) begin
            sd_cnt_d = '0;
        end else if (tick_game) begin
            if (sd_cnt_inc == SDR_N) begin
                set_v[P_D] = 1'b1;
                sd_cnt_d   = '0;
            end else begin
                sd_cnt_d = sd_cnt_inc;
            end
        end

        // dir encodes the btn index directly: 0 = left, 1 = right.
        case (state_q)
            S_IDLE: begin
                if (|sh_press) begin
                    sh_set   = sh_press;
                    dir_d    = sh_press[1];
                    sh_cnt_d = '0;
                    state_d  = S_DAS;
                end
            end
            S_DAS, S_ARR: begin
                if (sh_press[~dir_q]) begin
                    sh_set[~dir_q] = 1'b1;
                    dir_d    = ~dir_q;
                    sh_cnt_d = '0;
                    state_d  = S_DAS;
                end else if (!sh_btn[dir_q]) begin
                    sh_cnt_d = '0;
                    if (sh_btn[~dir_q]) begin
                        dir_d   = ~dir_q;
                        state_d = S_DAS;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (tick_game) begin
                    if (sh_cnt_inc == sh_limit) begin
                        sh_set[dir_q] = 1'b1;
                        sh_cnt_d = '0;
                        state_d  = S_ARR;
                    end else begin
                        sh_cnt_d = sh_cnt_inc;
                    end
                end
            end
            default: begin
                state_d  = S_IDLE;
                sh_cnt_d = '0;
            end
        endcase

        set_v[P_L] = sh_set[0];
        set_v[P_R] = sh_set[1];

        if (issue_ok) begin
            if (pend_q[P_DROP])     cmd_d[P_DROP] = 1'b1;
            else if (pend_q[P_ROT]) cmd_d[P_ROT]  = 1'b1;
            else if (pend_q[P_L])   cmd_d[P_L]    = 1'b1;
            else if (pend_q[P_R])   cmd_d[P_R]    = 1'b1;
            else if (pend_q[P_D])   cmd_d[P_D]    = 1'b1;
        end

        // A fresh request in the issue cycle survives the clear; flush beats both.
        pend_d = flush ? 5'b0 : ((pend_q & ~cmd_d) | set_v);
    end

    assign cmd_left   = cmd_q[P_L];
    assign cmd_right  = cmd_q[P_R];
    assign cmd_down   = cmd_q[P_D];
    assign cmd_rotate = cmd_q[P_ROT];
    assign cmd_drop   = cmd_q[P_DROP];
endmodule
